// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first, one bit per clock
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             Overflow,
`endif
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_fa_s;
    logic             w_fa_co;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    full_adder u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_fa_s, r_res[WIDTH-1:1]};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (r_state)
            S_RUN:   Busy = 1'b1;
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

    // Sum/Cout load straight from the final bit so they never expose a partial result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_fa_co;
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum  <= w_res_next;
                        r_cout <= w_fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // r_carry here is the carry into the MSB.
                        r_ovf  <= r_carry ^ w_fa_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign Overflow = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl (WIDTH=16)

module tb_serial_add_ctrl;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Cin = 1'b0;
    logic        Busy;
    logic        Done;
    logic [15:0] Sum;
    logic        Cout;
`ifdef SERIAL_ADD_OVF_EN
    logic        Overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(16)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
`ifdef SERIAL_ADD_OVF_EN
        .Overflow (Overflow),
`endif
        .Cout  (Cout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one operation from IDLE and follow it to Done; edge count includes the accept edge.
    task automatic do_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] es, input logic ec);
        int edges;
        int busy_cyc;
        @(negedge Clk);
        Start = 1'b1; A = a; B = b; Cin = c;
        @(negedge Clk);
        Start = 1'b0;
        edges = 1;
        busy_cyc = 0;
        while (!Done && edges < 40) begin
            if (Busy) busy_cyc++;
            @(negedge Clk);
            edges++;
        end
        chk({tag, ".latency"}, edges, 17);
        chk({tag, ".busy_cycles"}, busy_cyc, 16);
        chk({tag, ".busy_in_done"}, Busy, 0);
        chk({tag, ".sum"}, Sum, es);
        chk({tag, ".cout"}, Cout, ec);
        @(negedge Clk);
        chk({tag, ".done_pulse"}, Done, 0);
        chk({tag, ".sum_held"}, Sum, es);
    endtask

    initial begin
        int edges;
        int pulses;

        #12;
        chk("reset.busy", Busy, 0);
        chk("reset.done", Done, 0);
        chk("reset.sum", Sum, 0);
        chk("reset.cout", Cout, 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        do_add("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        do_add("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        chk("ffff_p1.ovf", Overflow, 0);
`endif
        do_add("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        chk("7fff_p1.ovf", Overflow, 1);
`endif
        do_add("ffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Start during RUN must be ignored
        @(negedge Clk);
        Start = 1'b1; A = 16'h1111; B = 16'h2222; Cin = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        Start = 1'b1; A = 16'hAAAA; B = 16'h5555; Cin = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (Done) pulses++;
            @(negedge Clk);
        end
        chk("ignore.done_pulses", pulses, 1);
        chk("ignore.sum", Sum, 16'h3333);
        chk("ignore.cout", Cout, 0);
        chk("ignore.idle", Busy, 0);

        // Asynchronous reset mid-RUN
        @(negedge Clk);
        Start = 1'b1; A = 16'h00FF; B = 16'h0101; Cin = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        repeat (8) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("areset.busy", Busy, 0);
        chk("areset.done", Done, 0);
        chk("areset.sum", Sum, 0);
        chk("areset.cout", Cout, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (Done) pulses++;
        end
        Rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Done || Busy) pulses++;
        end
        chk("areset.no_done", pulses, 0);
        do_add("after_reset", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

        // Start held high: one operation per 18 cycles
        @(negedge Clk);
        Start = 1'b1; A = 16'h0001; B = 16'h0002; Cin = 1'b0;
        edges = 0;
        while (!Done && edges < 40) begin
            @(negedge Clk);
            edges++;
        end
        chk("b2b.first_done", Done, 1);
        chk("b2b.sum", Sum, 16'h0003);
        edges = 0;
        @(negedge Clk);
        edges++;
        while (!Done && edges < 40) begin
            @(negedge Clk);
            edges++;
        end
        chk("b2b.period", edges, 18);
        Start = 1'b0;
        repeat (2) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
